load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the core's datapath (ALU result, rs2 data, decoder memread/memwrite)
//  and a handshaked data memory. Replaces the zero-wait data_memory hookup.
//  Does RISC-V byte/half/word alignment, byte enables and load sign/zero extension.
//  Holds the core via stall until the memory acknowledges, or a timeout fires.
// PARAMETERS
//  TIMEOUT   255   max ACCESS cycles without mem_ack before abort (1..255)
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rst          in   1   asynchronous, active-high reset
//  req_valid    in   1   core requests a load/store (memread | memwrite)
//  req_we       in   1   1 = store, 0 = load
//  req_funct3   in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr     in   32  byte address (ALU result)
//  req_wdata    in   32  store data (rs2)
//  stall        out  1   core must hold pc/regwrite and keep request inputs stable
//  load_data    out  32  aligned, extended load result; valid with load_valid
//  load_valid   out  1   one-cycle pulse, load finished
//  misalign     out  1   one-cycle pulse, misaligned or illegal-funct3 request
//  timeout_err  out  1   one-cycle pulse, access aborted on timeout
//  mem_req      out  1   memory request, held until mem_ack
//  mem_we       out  1   write strobe qualifier
//  mem_addr     out  32  word-aligned address ({req_addr[31:2],2'b00})
//  mem_wdata    out  32  lane-replicated store data
//  mem_be       out  4   byte enables (bit0 = byte at addr[1:0]=00)
//  mem_ack      in   1   memory done; sampled only while mem_req=1
//  mem_rdata    in   32  read word; valid in the mem_ack cycle
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, timeout counter 0. Async: mem_req drops with rst
//   and no clock edge. A reset mid-ACCESS abandons the transfer; no pulses fire.
//  FSM states: IDLE, ACCESS, RESP.
//  - IDLE: when req_valid=1 and the request is legal, latch addr/we/funct3/wdata and
//    go to ACCESS. stall=1 combinationally in that cycle.
//  - IDLE, illegal request: misalign=1 for that cycle, stall=0, stay in IDLE, no
//    memory access. Illegal means: funct3 in {011,110,111}; H/HU with addr[0]=1;
//    W with addr[1:0]!=0.
//  - ACCESS: mem_req=1, with mem_addr/mem_we/mem_be/mem_wdata from the latched values
//    and stable. stall=1.
//    On mem_ack=1: capture extended data (loads only) and go to RESP.
//    Else the counter increments. If the counter reaches TIMEOUT: timeout_err=1 on
//    entering RESP, load_data=0.
//  - RESP: stall=0, load_valid=1 if it was a load that was acked. The core retires
//    the instruction at this edge. req_valid is ignored in RESP. Next state is IDLE,
//    counter cleared.
//  - Latency: ack in the first ACCESS cycle gives 2 stall cycles, then RESP.
//    Each wait cycle adds 1.
//  - mem_ack outside ACCESS is ignored. load_data holds its value until the next load
//    completes.
//  Store lanes:
//  - SB: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
//  - SH: be=addr[1]?1100:0011, wdata={2{wdata[15:0]}}.
//  - SW: be=1111.
//  Loads: be=1111, mem_we=0.
//  - Lane select: byte=rdata[8*addr[1:0]+:8], half=rdata[16*addr[1]+:16].
//  - B/H sign-extend, BU/HU zero-extend, W as-is.
// TESTING
//  1 LW 0x100, ack after 2 wait cycles, rdata=0xDEADBEEF
//    -> stall high 4 cycles; then load_valid pulse with load_data=0xDEADBEEF.
//  2 LB 0x103, rdata=0x80123456 -> 0xFFFFFF80. LBU same -> 0x00000080.
//    LHU 0x102 -> 0x00008012.
//  3 SH 0x102, wdata=0x1234ABCD -> mem_addr=0x100, mem_be=1100, mem_wdata=0xABCDABCD,
//    mem_we=1. SB 0x101 -> be=0010.
//  4 LW 0x102, or funct3=011 -> misalign pulse; mem_req never rises; stall=0
//    the same cycle.
//  5 TIMEOUT=8, never ack -> mem_req high 8 cycles; timeout_err pulse; load_valid=0;
//    back to IDLE.
//  6 rst high mid-ACCESS, between edges -> mem_req=0 immediately; then a new LW
//    completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bus bundle between the core datapath, the load/store unit and the data memory.
interface load_store_if;
  // Core request side
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // Core response side
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misalign;
  logic        timeout_err;
  // Data memory side
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // Core + memory view: drives requests and memory responses
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    input  stall, load_data, load_valid, misalign, timeout_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  // Load/store unit view
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    output stall, load_data, load_valid, misalign, timeout_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: aligns RISC-V byte/half/word accesses onto a handshaked
// word-wide data memory, stalls the core until ack or timeout, and returns
// sign/zero-extended load data.
module load_store_unit #(
  parameter int TIMEOUT = 255  // max ACCESS cycles without mem_ack (1..255)
) (
  input  logic         clk,
  input  logic         rst,
  load_store_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        timeout_err_q, timeout_err_d;

  logic        req_legal;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] load_ext;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Request legality: known funct3 and natural alignment for half/word
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    req_legal = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b100: req_legal = 1'b1;
      3'b001, 3'b101: req_legal = ~bus.req_addr[0];
      3'b010:         req_legal = (bus.req_addr[1:0] == 2'b00);
      default:        req_legal = 1'b0;
    endcase
  end

  // Store lane steering and byte enables from the latched request
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = wdata_q;
    if (we_q) begin
      case (funct3_q[1:0])
        2'b00: begin
          lane_be    = 4'b0001 << addr_q[1:0];
          lane_wdata = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
          lane_wdata = {2{wdata_q[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Load lane select and sign/zero extension of the returned word
  always_comb begin
    rd_byte  = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    rd_half  = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    load_ext = bus.mem_rdata;
    case (funct3_q)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_ext = {24'h000000, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_ext = {16'h0000, rd_half};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  // FSM next state, request latching, timeout counting and response flags
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    we_d          = we_q;
    funct3_d      = funct3_q;
    wdata_d       = wdata_q;
    load_data_d   = load_data_q;
    load_valid_d  = 1'b0;
    timeout_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && req_legal) begin
          addr_d   = bus.req_addr;
          we_d     = bus.req_we;
          funct3_d = bus.req_funct3;
          wdata_d  = bus.req_wdata;
          cnt_d    = 8'd0;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (bus.mem_ack) begin
          state_d = RESP;
          if (!we_q) begin
            load_data_d  = load_ext;
            load_valid_d = 1'b1;
          end
        end else if (cnt_q == LAST_WAIT) begin
          state_d       = RESP;
          timeout_err_d = 1'b1;
          load_data_d   = 32'h0000_0000;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      addr_q        <= 32'h0000_0000;
      we_q          <= 1'b0;
      funct3_q      <= 3'b000;
      wdata_q       <= 32'h0000_0000;
      load_data_q   <= 32'h0000_0000;
      load_valid_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      we_q          <= we_d;
      funct3_q      <= funct3_d;
      wdata_q       <= wdata_d;
      load_data_q   <= load_data_d;
      load_valid_q  <= load_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Output decode: stall/misalign react to the request in IDLE, memory bus
  // is driven only while ACCESS so it idles at zero
  always_comb begin
    bus.stall       = (state_q == ACCESS) ||
                      ((state_q == IDLE) && bus.req_valid && req_legal);
    bus.misalign    = (state_q == IDLE) && bus.req_valid && !req_legal;
    bus.load_data   = load_data_q;
    bus.load_valid  = load_valid_q;
    bus.timeout_err = timeout_err_q;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = 32'h0000_0000;
    bus.mem_wdata   = 32'h0000_0000;
    bus.mem_be      = 4'b0000;
    if (state_q == ACCESS) begin
      bus.mem_req   = 1'b1;
      bus.mem_we    = we_q;
      bus.mem_addr  = {addr_q[31:2], 2'b00};
      bus.mem_wdata = lane_wdata;
      bus.mem_be    = lane_be;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: drives core requests, plays the
// memory, and scoreboards load/timeout responses.
module tb_load_store_unit;

  localparam int TMO = 8;

  typedef struct {
    logic        lv;
    logic        te;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;
  load_store_if bus ();

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  load_store_unit #(.TIMEOUT(TMO)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference extension model: shift the word down, then extend by width
  function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (addr[1:0] * 8);
    case (f3)
      3'b000:  return 32'($signed(sh[7:0]));
      3'b100:  return sh & 32'h0000_00FF;
      3'b001:  return 32'($signed(sh[15:0]));
      3'b101:  return sh & 32'h0000_FFFF;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] be_model(input logic we, input logic [2:0] f3,
                                          input logic [31:0] addr);
    if (!we) return 4'hF;
    case (f3[1:0])
      2'b00:   return 4'(1 << addr[1:0]);
      2'b01:   return addr[1] ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] wd_model(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      2'b01:   return {wd[15:0], wd[15:0]};
      default: return wd;
    endcase
  endfunction

  // Response monitor: every load_valid/timeout_err pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (bus.load_valid || bus.timeout_err) begin
      if (sb_q.size() == 0) begin
        chk("spurious_pulse", {30'd0, bus.load_valid, bus.timeout_err}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("resp_kind", {30'd0, bus.load_valid, bus.timeout_err}, {30'd0, e.lv, e.te});
        chk("resp_data", bus.load_data, e.data);
      end
    end
  end

  // One legal transaction; waits < 0 means the memory never acknowledges
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int waits);
    int   stall_n;
    int   acc_n;
    logic done;
    exp_t e;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    if (waits < 0) begin
      e.lv = 1'b0; e.te = 1'b1; e.data = 32'h0;
      sb_q.push_back(e);
    end else if (!we) begin
      e.lv = 1'b1; e.te = 1'b0; e.data = ext_model(f3, addr, rdata);
      sb_q.push_back(e);
    end
    #1;
    chk("idle_stall", {31'd0, bus.stall}, 32'd1);
    chk("idle_misalign", {31'd0, bus.misalign}, 32'd0);
    stall_n = 1;
    acc_n   = 0;
    done    = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      #1;
      if (!bus.stall) begin
        done = 1'b1;
      end else begin
        stall_n++;
        if (bus.mem_req) acc_n++;
        if (acc_n == 1) begin
          chk("mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
          chk("mem_we", {31'd0, bus.mem_we}, {31'd0, we});
          chk("mem_be", {28'd0, bus.mem_be}, {28'd0, be_model(we, f3, addr)});
          if (we) chk("mem_wdata", bus.mem_wdata, wd_model(f3, wdata));
        end
        if (acc_n == waits + 1) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rdata;
        end
      end
    end
    chk("op_done", {31'd0, done}, 32'd1);
    bus.req_valid = 1'b0;
    chk("stall_cycles", stall_n, (waits < 0) ? TMO + 1 : waits + 2);
    chk("mem_req_cycles", acc_n, (waits < 0) ? TMO : waits + 1);
    chk("resp_mem_req", {31'd0, bus.mem_req}, 32'd0);
  endtask

  // Illegal request: misalign pulse, no stall, no memory access
  task automatic bad_op(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = 32'h5555_AAAA;
    #1;
    chk("bad_misalign", {31'd0, bus.misalign}, 32'd1);
    chk("bad_stall", {31'd0, bus.stall}, 32'd0);
    chk("bad_mem_req", {31'd0, bus.mem_req}, 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    chk("bad_after_mem_req", {31'd0, bus.mem_req}, 32'd0);
  endtask

  initial begin
    logic [2:0]  f3s [5];
    logic [31:0] a;
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = 32'h0;
    #3;
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_be", {28'd0, bus.mem_be}, 32'd0);
    chk("rst_load_data", bus.load_data, 32'd0);
    chk("rst_pulses", {29'd0, bus.load_valid, bus.timeout_err, bus.misalign}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Word load with two wait cycles
    do_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2);

    // Byte/half loads with extension
    do_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0);
    do_op(1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 1);
    do_op(1'b0, 3'b101, 32'h102, 32'h0, 32'h80123456, 0);
    do_op(1'b0, 3'b001, 32'h102, 32'h0, 32'h80123456, 0);
    do_op(1'b0, 3'b000, 32'h100, 32'h0, 32'h80123456, 0);

    // Stores: lanes and byte enables; load_data must hold
    do_op(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 1);
    do_op(1'b1, 3'b001, 32'h200, 32'h1234ABCD, 32'h0, 0);
    for (int i = 0; i < 4; i++)
      do_op(1'b1, 3'b000, 32'h100 + 32'(i), 32'hCAFE00A5 + 32'(i), 32'h0, i);
    do_op(1'b1, 3'b010, 32'h104, 32'h01234567, 32'h0, 0);
    chk("load_data_hold", bus.load_data, 32'h0000_0056);

    // Illegal requests
    bad_op(1'b0, 3'b010, 32'h102);
    bad_op(1'b0, 3'b011, 32'h100);
    bad_op(1'b0, 3'b001, 32'h101);
    bad_op(1'b1, 3'b110, 32'h100);

    // Timeout on a load that is never acknowledged
    do_op(1'b0, 3'b010, 32'h300, 32'h0, 32'h0, -1);
    chk("timeout_load_data", bus.load_data, 32'h0);

    // Random legal loads
    for (int i = 0; i < 6; i++) begin
      logic [2:0] f;
      f = f3s[$urandom_range(0, 4)];
      a = $urandom & 32'hFFFF_FFFC;
      if (f[1:0] == 2'b00) a = a | 32'($urandom_range(0, 3));
      else if (f[1:0] == 2'b01) a = a | (32'($urandom_range(0, 1)) << 1);
      do_op(1'b0, f, a, 32'h0, $urandom, int'($urandom_range(0, 3)));
    end

    // Asynchronous reset in the middle of an access
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h400;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_mem_req", {31'd0, bus.mem_req}, 32'd1);
    #2;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("async_rst_stall", {31'd0, bus.stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b0, 3'b010, 32'h400, 32'h0, 32'h13572468, 1);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
